sad_result_reader: RTL and testbench
====================================

Name: sad_result_reader

Overview:
- Avalon-MM fixed-latency master that drains one edge-capture PIO input port, such as the SAD result high/low ports.
- When armed, it polls the port's edge-capture register until any bit is set, clears the capture, reads the data register, and presents the word on a valid/ready stream.
- Sits between the SAD PIO slaves and the result-collection logic, so the CPU no longer has to poll.

Parameters:
- DATA_W, 32: width of the PIO data and capture registers.
- POLL_GAP, 4: idle cycles between consecutive capture polls (0 allowed).
- TIMEOUT_CYCLES, 1024: poll-loop cycle budget when the timeout feature is compiled in.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle arm pulse
- avm_address  out  2  PIO register address (0 = data, 3 = edge capture)
- avm_chipselect  out  1  slave select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  slave read data; registered, valid one cycle after the address
- result_data  out  DATA_W  captured data word
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE
- timeout  out  1  sticky timeout flag (feature only; tied 0 otherwise)

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: FSM=IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, result_data=0, result_valid=0, busy=0, timeout=0. All outputs are registered.
- Read protocol:
  - The address is driven with chipselect=1 and write_n=1 for one cycle.
  - avm_readdata is sampled on the next cycle.
  - Fixed latency 1; no waitrequest.
- Write protocol: one cycle with chipselect=1, write_n=0, address=3, writedata=all ones. This clears the whole capture register.
- FSM states:
  - IDLE: on start go to POLL_REQ.
  - POLL_REQ: drive a read at address 3; go to POLL_WAIT.
  - POLL_WAIT: sample readdata. If nonzero go to CLEAR. If zero go to GAP, or to POLL_REQ when POLL_GAP=0.
  - GAP: count POLL_GAP cycles, then go to POLL_REQ.
  - CLEAR: drive the write; go to DATA_REQ.
  - DATA_REQ: drive a read at address 0; go to DATA_WAIT.
  - DATA_WAIT: load result_data from readdata, set result_valid; go to OUT.
  - OUT: hold result_valid and result_data stable until result_ready=1. Handshake completes that cycle; result_valid drops the next cycle; FSM returns to IDLE.
- Clear comes before the data read, so the returned data is never older than the edge that triggered it. An edge arriving in the same cycle as the clear is lost by the slave (clear has priority). A later edge is recaptured for the next transaction.
- Best-case latency from start to result_valid: 6 cycles (POLL_REQ, POLL_WAIT, CLEAR, DATA_REQ, DATA_WAIT, then OUT).
- start is ignored while busy=1. A start in the same cycle that OUT completes is also ignored.
- Bus signals are idle (chipselect=0, write_n=1) in every state other than *_REQ and CLEAR.
- reset_n asserted mid-operation: immediate return to the reset values; any in-flight result is discarded.

Optional Feature:
- Macro: SAD_READER_TIMEOUT_EN.
- With the macro: a counter runs from POLL_REQ entry through the poll loop. After TIMEOUT_CYCLES without a nonzero capture, the FSM goes to IDLE and sets timeout=1. timeout is sticky and is cleared by the next start. The counter resets on each new start.
- Without the macro: the FSM polls indefinitely, timeout is constant 0, and no counter logic exists.

Decomposition:
- Shared package sad_reader_pkg holds:
  - state enum: IDLE, POLL_REQ, POLL_WAIT, GAP, CLEAR, DATA_REQ, DATA_WAIT, OUT
  - PIO address constants: ADDR_DATA=0, ADDR_EDGE_CAP=3
  - CLEAR_WORD = all ones
- One natural sub-module: sad_reader_gap_timer, a loadable down-counter reused for the poll gap and the timeout.

Test Plan:
- Single result: PIO capture pre-set to 0x0000_0100 and data=0x1234_5678, pulse start → one write to address 3 observed, result_data=0x1234_5678, result_valid high 6 cycles after start.
- Polling gap: capture=0 for 3 polls, then 0x1 → exactly 4 reads at address 3, spaced POLL_GAP+2=6 cycles apart, then the clear and the data read.
- Backpressure: result_ready held low 10 cycles → result_valid and result_data stable for all 10; no bus activity; busy=1 throughout.
- Edge coincident with clear: in_port rises in the CLEAR cycle → that edge is not captured; a following start with a later edge returns the new data.
- Reset mid-poll: reset_n low in the GAP state → all outputs return to reset values immediately; start after release proceeds normally.
- SAD_READER_TIMEOUT_EN with TIMEOUT_CYCLES=64: capture held at 0 → timeout=1 and busy=0 within 64 cycles; the next start clears timeout.

Source files
------------

// File: rtl/sad_reader_pkg.sv
// Shared types and constants for the SAD result reader: FSM states, PIO register map, clear word.
`default_nettype none

package sad_reader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POLL_REQ  = 3'd1,
    POLL_WAIT = 3'd2,
    GAP       = 3'd3,
    CLEAR     = 3'd4,
    DATA_REQ  = 3'd5,
    DATA_WAIT = 3'd6,
    OUT       = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // Wide enough for any supported DATA_W; the top slices off what it needs.
  localparam int          CLEAR_WORD_MAX_W = 64;
  localparam logic [63:0] CLEAR_WORD       = '1;

  // Bits needed to hold a down-counter preload of n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sad_reader_gap_timer.sv
// Loadable down-counter that saturates at zero; expired_o is high while the count is zero.
`default_nettype none

module sad_reader_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/sad_result_reader.sv
// Avalon-MM master that polls a PIO edge-capture register, clears it, reads the data port and streams the word out.
// Optional poll-loop timeout is compiled in with SAD_READER_TIMEOUT_EN.
`default_nettype none

module sad_result_reader
  import sad_reader_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              timeout
);

  localparam int               GAP_W    = cnt_width(POLL_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  if (POLL_GAP < 0 || TIMEOUT_CYCLES < 1 || DATA_W > CLEAR_WORD_MAX_W) begin : g_param_check
    $error("sad_result_reader: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic                gap_load, gap_dec, gap_expired;
  logic [1:0]          avm_address_q;
  logic                avm_chipselect_q;
  logic                avm_write_n_q;
  logic [DATA_W-1:0]   avm_writedata_q;
  logic [DATA_W-1:0]   result_data_q;
  logic                result_valid_q;
  logic                busy_q;

  sad_reader_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .expired_o  (gap_expired)
  );

`ifdef SAD_READER_TIMEOUT_EN
  localparam int              TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic to_load, to_dec, to_expired;
  logic timeout_q, timeout_d;

  sad_reader_gap_timer #(.W(TO_W)) u_timeout_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .dec_i      (to_dec),
    .expired_o  (to_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`ifdef SAD_READER_TIMEOUT_EN
    to_load   = 1'b0;
    to_dec    = 1'b0;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = POLL_REQ;
`ifdef SAD_READER_TIMEOUT_EN
          to_load   = 1'b1;
          timeout_d = 1'b0;
`endif
        end
      end
      POLL_REQ:  state_d = POLL_WAIT;
      POLL_WAIT: begin
        if (avm_readdata != '0) begin
          state_d = CLEAR;
        end else if (POLL_GAP == 0) begin
          state_d = POLL_REQ;
        end else begin
          state_d  = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        if (gap_expired) state_d = POLL_REQ;
        else             gap_dec = 1'b1;
      end
      CLEAR:     state_d = DATA_REQ;
      DATA_REQ:  state_d = DATA_WAIT;
      DATA_WAIT: state_d = OUT;
      OUT:       if (result_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`ifdef SAD_READER_TIMEOUT_EN
    // A capture seen on the final budgeted cycle still wins over the timeout.
    if (state_q inside {POLL_REQ, POLL_WAIT, GAP}) begin
      to_dec = 1'b1;
      if (to_expired && (state_d != CLEAR)) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
      end
    end
`endif
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      avm_address_q    <= ADDR_DATA;
      avm_chipselect_q <= 1'b0;
      avm_write_n_q    <= 1'b1;
      avm_writedata_q  <= '0;
      result_data_q    <= '0;
      result_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      avm_chipselect_q <= (state_d inside {POLL_REQ, CLEAR, DATA_REQ});
      avm_write_n_q    <= (state_d != CLEAR);
      avm_address_q    <= (state_d inside {POLL_REQ, CLEAR}) ? ADDR_EDGE_CAP : ADDR_DATA;
      avm_writedata_q  <= (state_d == CLEAR) ? CLEAR_WORD[DATA_W-1:0] : '0;
      if (state_q == DATA_WAIT) result_data_q <= avm_readdata;
      result_valid_q   <= (state_d == OUT);
      busy_q           <= (state_d != IDLE);
    end
  end

  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_writedata  = avm_writedata_q;
  assign result_data    = result_data_q;
  assign result_valid   = result_valid_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sad_result_reader.sv
// Directed bench for sad_result_reader with a behavioural edge-capture PIO slave.
`default_nettype none

module tb_sad_result_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        result_ready = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic [31:0] result_data;
  logic        result_valid;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  sad_result_reader #(.DATA_W(32), .POLL_GAP(4), .TIMEOUT_CYCLES(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy),
    .timeout        (timeout)
  );

  // PIO slave: data = in_port, edge capture at address 3 (write-one-to-clear, clear wins).
  logic [31:0] in_port   = 32'h1234_5678;
  logic [31:0] in_prev   = 32'h1234_5678;
  logic [31:0] cap       = 32'h0;
  logic [31:0] cap_force = 32'h0;
  logic [31:0] rdata     = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] poll_t [0:63];
  int cyc = 0, polls = 0, writes = 0, dreads = 0, busacc = 0;

  assign avm_readdata = rdata;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    in_prev <= in_port;
    if (avm_chipselect) busacc <= busacc + 1;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
      cap        <= cap & ~avm_writedata;
      writes     <= writes + 1;
      last_wdata <= avm_writedata;
    end else begin
      cap <= cap | (in_port & ~in_prev) | cap_force;
    end
    if (avm_chipselect && avm_write_n) begin
      rdata <= (avm_address == 2'd0) ? in_port : (avm_address == 2'd3) ? cap : 32'h0;
      if (avm_address == 2'd3) begin
        poll_t[polls[5:0]] <= cyc;
        polls <= polls + 1;
      end
      if (avm_address == 2'd0) dreads <= dreads + 1;
    end else begin
      rdata <= 32'h0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic force_cap(input logic [31:0] v);
    cap_force = v;
    @(negedge clk);
    cap_force = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, d0, b0, n;

    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_valid",  {31'd0, result_valid}, 32'd0);
    check("rst_cs",     {31'd0, avm_chipselect}, 32'd0);
    check("rst_wn",     {31'd0, avm_write_n}, 32'd1);
    check("rst_addr",   {30'd0, avm_address}, 32'd0);
    check("rst_wdata",  avm_writedata, 32'd0);
    check("rst_data",   result_data, 32'd0);
    check("rst_tmo",    {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single result with capture already pending
    p0 = polls; w0 = writes; d0 = dreads;
    force_cap(32'h0000_0100);
    pulse_start();
    repeat (4) @(negedge clk);
    check("t1_valid_early", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_at_6",  {31'd0, result_valid}, 32'd1);
    check("t1_data",        result_data, 32'h1234_5678);
    check("t1_writes",      writes - w0, 32'd1);
    check("t1_polls",       polls - p0, 32'd1);
    check("t1_dreads",      dreads - d0, 32'd1);
    check("t1_clear_word",  last_wdata, 32'hFFFF_FFFF);
    check("t1_busy",        {31'd0, busy}, 32'd1);
    handshake();
    check("t1_valid_drop",  {31'd0, result_valid}, 32'd0);
    check("t1_idle",        {31'd0, busy}, 32'd0);

    // Polling gap: three empty polls, then a capture (only falling bits on in_port)
    in_port = 32'h1030_5070;
    @(negedge clk);
    p0 = polls; w0 = writes; d0 = dreads;
    pulse_start();
    repeat (15) @(negedge clk);
    force_cap(32'h0000_0001);
    wait_valid(n);
    check("t2_latency", n, 32'd7);
    check("t2_polls",   polls - p0, 32'd4);
    for (int i = 0; i < 3; i++)
      check("t2_spacing", poll_t[p0 + i + 1] - poll_t[p0 + i], 32'd6);
    check("t2_writes",  writes - w0, 32'd1);
    check("t2_dreads",  dreads - d0, 32'd1);
    check("t2_data",    result_data, 32'h1030_5070);
    handshake();

    // Backpressure
    in_port = 32'h0030_5070;
    @(negedge clk);
    force_cap(32'h0000_0002);
    pulse_start();
    wait_valid(n);
    b0 = busacc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_valid_hold", {31'd0, result_valid}, 32'd1);
      check("t3_data_hold",  result_data, 32'h0030_5070);
      check("t3_busy_hold",  {31'd0, busy}, 32'd1);
    end
    check("t3_no_bus", busacc - b0, 32'd0);
    handshake();
    check("t3_valid_drop", {31'd0, result_valid}, 32'd0);

    // Edge coincident with the clear is lost
    force_cap(32'h0000_0004);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("t4_in_clear", {31'd0, avm_write_n}, 32'd0);
    in_port = 32'h8030_5070;
    wait_valid(n);
    check("t4_data",      result_data, 32'h8030_5070);
    check("t4_cap_empty", cap, 32'd0);
    handshake();
    pulse_start();
    repeat (12) @(negedge clk);
    check("t4_no_stale", {31'd0, result_valid}, 32'd0);
    in_port = 32'hC030_5070;
    wait_valid(n);
    check("t4_new_data", result_data, 32'hC030_5070);
    handshake();

    // Reset while in GAP
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("t5_in_gap_busy", {31'd0, busy}, 32'd1);
    check("t5_in_gap_cs",   {31'd0, avm_chipselect}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_busy",  {31'd0, busy}, 32'd0);
    check("t5_rst_cs",    {31'd0, avm_chipselect}, 32'd0);
    check("t5_rst_wn",    {31'd0, avm_write_n}, 32'd1);
    check("t5_rst_addr",  {30'd0, avm_address}, 32'd0);
    check("t5_rst_data",  result_data, 32'd0);
    check("t5_rst_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_stay_idle", {31'd0, busy}, 32'd0);
    force_cap(32'h0000_0008);
    pulse_start();
    wait_valid(n);
    check("t5_latency", n, 32'd5);
    check("t5_data",    result_data, 32'hC030_5070);
    handshake();

`ifdef SAD_READER_TIMEOUT_EN
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout_set", {31'd0, timeout}, 32'd1);
    check("t6_within_64",   {31'd0, (n <= 64)}, 32'd1);
    pulse_start();
    check("t6_timeout_clr", {31'd0, timeout}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
